// File: rtl/shape_view_ctrl_pkg.sv
// Shared definitions for the shape display-mode controller and the object
// modules that consume its outputs.
//   - view_state_t : display mode encoding (ST_MOSAIC = 0, ST_FULL = 1)
//   - H_LAST_DEF / V_LAST_DEF : default raster limits, kept here so the sync
//     generator, the objects and this controller agree on the frame boundary
//   - SHAPE_* : bit index of each object inside the one-hot shape select
package shape_view_ctrl_pkg;

  typedef enum logic {
    ST_MOSAIC = 1'b0,
    ST_FULL   = 1'b1
  } view_state_t;

  localparam int H_LAST_DEF = 799;
  localparam int V_LAST_DEF = 524;

  localparam int SHAPE_TRIANGLE = 0;
  localparam int SHAPE_SQUARE   = 1;
  localparam int SHAPE_OVAL     = 2;
  localparam int SHAPE_CIRCLE   = 3;

endpackage

// File: rtl/shape_view_ctrl_btn_debounce.sv
// btn_debounce: conditions one raw push-button.
//   clk, reset : pixel clock, synchronous active-high reset
//   btn        : raw asynchronous, bouncy button level
//   req        : one-cycle pulse when the debounced level rises
// The raw level passes a 2-flop synchroniser. A counter measures how long the
// synchronised level has disagreed with the accepted level; any agreement
// reloads it, and DEBOUNCE_CYCLES consecutive disagreeing samples flip the
// accepted level.
module btn_debounce
  import shape_view_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic req
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      req     <= 1'b0;
    end else begin
      // synchroniser stage
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // debounce stage
      req <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync_p1;
        // only a 0->1 acceptance is a request; releases are silent
        req   <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shape_view_ctrl.sv
// shape_view_ctrl: display-mode controller for the VGA shape objects.
//   clk, reset     : pixel clock, synchronous active-high reset
//   HCount, VCount : raster position from the sync generator
//   btn_next/prev/full : raw buttons (advance, step back, toggle full screen)
//   shape_sel      : one-hot selected shape (registered)
//   full_screen    : 1 = only the selected shape is drawn (registered)
//   frame_start    : one-cycle pulse on the cycle after updates are applied
// Button requests are latched as pending flags and only applied on the last
// pixel of the frame, so a frame never shows a half-updated mode.
// Optional feature macro: AUTO_CYCLE_EN -- in FULL view, advance the
// selection automatically every AUTO_FRAMES frames.
module shape_view_ctrl
  import shape_view_ctrl_pkg::*;
#(
  parameter int NUM_SHAPES      = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int H_LAST          = H_LAST_DEF,
  parameter int V_LAST          = V_LAST_DEF,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            HCount,
  input  logic [9:0]            VCount,
  input  logic                  btn_next,
  input  logic                  btn_prev,
  input  logic                  btn_full,
  output logic [NUM_SHAPES-1:0] shape_sel,
  output logic                  full_screen,
  output logic                  frame_start
);

  // the auto-cycle frame counter is 8 bits wide
  if (AUTO_FRAMES < 1 || AUTO_FRAMES > 256) begin : g_bad_auto_frames
    $error("AUTO_FRAMES must be in 1..256");
  end

  logic        req_next, req_prev, req_full;
  logic        pend_next, pend_prev, pend_full;
  logic        boundary;
  logic        auto_adv;
  view_state_t state;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
    .clk(clk), .reset(reset), .btn(btn_next), .req(req_next));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
    .clk(clk), .reset(reset), .btn(btn_prev), .req(req_prev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_full (
    .clk(clk), .reset(reset), .btn(btn_full), .req(req_full));

  assign boundary = (HCount == 10'(H_LAST)) && (VCount == 10'(V_LAST));

  function automatic logic [NUM_SHAPES-1:0] rot_left(input logic [NUM_SHAPES-1:0] s);
    return {s[NUM_SHAPES-2:0], s[NUM_SHAPES-1]};
  endfunction

  function automatic logic [NUM_SHAPES-1:0] rot_right(input logic [NUM_SHAPES-1:0] s);
    return {s[0], s[NUM_SHAPES-1:1]};
  endfunction

`ifdef AUTO_CYCLE_EN
  logic [7:0] auto_cnt;
  logic       pend_any;
  logic       req_any;

  assign pend_any = pend_next | pend_prev | pend_full;
  assign req_any  = req_next | req_prev | req_full;
  // A boundary that applies a button change never auto-advances too; the
  // button press restarts the frame count instead.
  assign auto_adv = boundary && (state == ST_FULL) && !pend_any && !req_any &&
                    (auto_cnt == 8'(AUTO_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      auto_cnt <= '0;
    end else if (req_any || state == ST_MOSAIC) begin
      auto_cnt <= '0;
    end else if (boundary) begin
      if (pend_any || auto_adv) auto_cnt <= '0;
      else                      auto_cnt <= auto_cnt + 8'd1;
    end
  end
`else
  assign auto_adv = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      shape_sel   <= NUM_SHAPES'(1);
      full_screen <= 1'b0;
      frame_start <= 1'b0;
      pend_next   <= 1'b0;
      pend_prev   <= 1'b0;
      pend_full   <= 1'b0;
      state       <= ST_MOSAIC;
    end else begin
      frame_start <= boundary;
      if (boundary) begin
        // opposing requests in one frame cancel out
        if (pend_next && pend_prev)  shape_sel <= shape_sel;
        else if (pend_next || auto_adv) shape_sel <= rot_left(shape_sel);
        else if (pend_prev)          shape_sel <= rot_right(shape_sel);
        if (pend_full) begin
          state       <= (state == ST_FULL) ? ST_MOSAIC : ST_FULL;
          full_screen <= (state == ST_MOSAIC);
        end
        // a request landing on the boundary itself waits for the next one
        pend_next <= req_next;
        pend_prev <= req_prev;
        pend_full <= req_full;
      end else begin
        pend_next <= pend_next | req_next;
        pend_prev <= pend_prev | req_prev;
        pend_full <= pend_full | req_full;
      end
    end
  end

endmodule

// File: tb/tb_shape_view_ctrl.sv
// Testbench for shape_view_ctrl with small raster/debounce parameters.
// Stimulus drives the raster counters and button presses frame by frame and
// pushes the expected post-boundary view into a queue; an independent monitor
// pops it whenever frame_start is seen.
module tb_shape_view_ctrl;

  localparam int NS = 4;
  localparam int DB = 4;
  localparam int HL = 9;
  localparam int VL = 4;
  localparam int AF = 3;
  localparam int FRAME_CYC = (HL + 1) * (VL + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [9:0]    hc = '0;
  logic [9:0]    vc = '0;
  logic          bn = 1'b0, bp = 1'b0, bf = 1'b0;
  logic [NS-1:0] shape_sel;
  logic          full_screen;
  logic          frame_start;

  always #5 clk = ~clk;

  shape_view_ctrl #(
    .NUM_SHAPES(NS), .DEBOUNCE_CYCLES(DB), .H_LAST(HL), .V_LAST(VL), .AUTO_FRAMES(AF)
  ) dut (
    .clk(clk), .reset(reset), .HCount(hc), .VCount(vc),
    .btn_next(bn), .btn_prev(bp), .btn_full(bf),
    .shape_sel(shape_sel), .full_screen(full_screen), .frame_start(frame_start)
  );

  typedef struct {
    logic [NS-1:0] sel;
    logic          full;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // reference view: selected index, full flag, frames spent idle in FULL
  int   m_idx  = 0;
  bit   m_full = 0;
  int   m_acnt = 0;

  bit   last_bnd = 0;
  bit   last_rst = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (hc == 10'(HL)) begin
      hc = '0;
      vc = (vc == 10'(VL)) ? 10'd0 : 10'(vc + 1);
    end else begin
      hc = 10'(hc + 1);
    end
  endtask

  function automatic logic press_level(input bit pressed, input int r);
    // short high, one-cycle dip (bounce), then a solid hold
    return pressed && r >= 0 && r < 14 && r != 2;
  endfunction

  task automatic push_expected();
    exp_t e;
    e.sel  = NS'(1) << m_idx;
    e.full = m_full;
    q.push_back(e);
  endtask

  // Runs one whole frame starting on its first cycle; returns on the first
  // cycle of the next frame.
  task automatic run_frame(input bit dn, input bit dp, input bit df, input bit drst);
    int sn, sp, sf;
    bit full_before;
    sn = drst ? 0 : int'($urandom_range(0, 8));
    sp = int'($urandom_range(0, 8));
    sf = int'($urandom_range(0, 8));
    full_before = m_full;
    if (drst) begin
      m_idx = 0; m_full = 0; m_acnt = 0;
    end else begin
      if (dn && !dp)      m_idx = (m_idx + 1) % NS;
      else if (dp && !dn) m_idx = (m_idx + NS - 1) % NS;
      if (df) m_full = !m_full;
`ifdef AUTO_CYCLE_EN
      if (dn || dp || df) m_acnt = 0;
      else if (full_before) begin
        m_acnt++;
        if (m_acnt == AF) begin
          m_acnt = 0;
          m_idx = (m_idx + 1) % NS;
        end
      end
`endif
    end
    push_expected();
    for (int t = 0; t < FRAME_CYC; t++) begin
      bn = press_level(dn, t - sn);
      if (drst) begin
        // prev is caught mid-debounce by the reset
        bp = (t >= 16 && t < 20);
        bf = 1'b0;
        reset = (t == 20 || t == 21);
      end else begin
        bp = press_level(dp, t - sp);
        bf = press_level(df, t - sf);
      end
      tick();
    end
  endtask

  // monitor: frame_start must follow each sampled boundary by one clock
  initial begin : monitor
    bit   exp_fs;
    exp_t e;
    forever begin
      @(negedge clk);
      exp_fs = last_bnd && !last_rst;
      if (frame_start || exp_fs) begin
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        if (frame_start) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_update: frame_start with no expected view queued");
          end else begin
            e = q.pop_front();
            check("shape_sel", 32'(shape_sel), 32'(e.sel));
            check("full_screen", 32'(full_screen), 32'(e.full));
          end
        end
      end
      last_bnd = (hc == 10'(HL)) && (vc == 10'(VL));
      last_rst = reset;
    end
  end

  // directed frames: {reset_mid, full, prev, next}
  logic [3:0] dir_tab [0:19] = '{
    4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0011, 4'b0000,
    4'b0101, 4'b0100, 4'b0001, 4'b1001, 4'b0000,
    4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
    4'b0000, 4'b0000, 4'b0000, 4'b0100
  };

  initial begin : stimulus
    logic [3:0] code;
    int         guard;
    reset = 1'b1;
    tick();
    tick();
    check("reset_shape_sel", 32'(shape_sel), 32'(4'b0001));
    check("reset_full_screen", 32'(full_screen), 32'd0);
    check("reset_frame_start", 32'(frame_start), 32'd0);
    reset = 1'b0;
    // the partial frame after reset ends in an idle boundary
    push_expected();
    guard = 0;
    while (!(hc == 10'd0 && vc == 10'd0) && guard < 2 * FRAME_CYC) begin
      tick();
      guard++;
    end
    if (guard >= 2 * FRAME_CYC) begin
      $display("FAIL frame_align: raster never reached origin");
      $fatal(1, "frame alignment lost");
    end

    for (int i = 0; i < 20; i++) begin
      code = dir_tab[i];
      run_frame(code[0], code[1], code[2], code[3]);
    end
    for (int i = 0; i < 40; i++) begin
      run_frame($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end
    tick();
    tick();
    tick();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
